// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with mid-bit sampling, one-byte buffer and error pulses.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx #(
    parameter int clk_freq       = 50000000,
    parameter int uart_baud_rate = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       UartRx,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_avail,
    output logic       frame_err,
    output logic       overrun_err,
`ifdef UART_RX_PARITY_EN
    output logic       parity_err,
`endif
    output logic       busy
);
    localparam int DIV  = clk_freq / uart_baud_rate;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      data_q, data_d;
    logic            avail_q, avail_d;
    logic            ferr_q, ferr_d;
    logic            oerr_q, oerr_d;
    logic            busy_q, busy_d;
    logic            sync_q, rx_s_q, rx_d_q;
    logic            commit;
`ifdef UART_RX_PARITY_EN
    logic            par_q, par_d;
    logic            perr_q, perr_d;
`endif

    // Next-state logic: the baud counter free-runs down outside IDLE; each state acts when it hits zero
    always_comb begin
        state_d   = state_q;
        cnt_d     = (state_q == IDLE || cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        ferr_d    = 1'b0;
        commit    = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (rx_d_q && !rx_s_q) begin
                    state_d = START;
                    cnt_d   = HALF_M1;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    state_d   = rx_s_q ? IDLE : DATA;
                    cnt_d     = DIV_M1;
                    bit_idx_d = 3'd0;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d   = {rx_s_q, shift_q[7:1]};
                    cnt_d     = DIV_M1;
                    bit_idx_d = bit_idx_q + 3'd1;
`ifdef UART_RX_PARITY_EN
                    if (bit_idx_q == 3'd7) state_d = PARITY;
`else
                    if (bit_idx_q == 3'd7) state_d = STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    par_d   = rx_s_q;
                    cnt_d   = DIV_M1;
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    ferr_d  = !rx_s_q;
`ifdef UART_RX_PARITY_EN
                    perr_d  = ^{shift_q, par_q};
                    commit  = rx_s_q && !perr_d;
`else
                    commit  = rx_s_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        avail_d = commit | (avail_q & ~rx_ack);
        oerr_d  = commit & avail_q & ~rx_ack;
        data_d  = commit ? shift_q : data_q;
        busy_d  = state_d != IDLE;
    end

    // All state, synchronizer and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            avail_q   <= 1'b0;
            ferr_q    <= 1'b0;
            oerr_q    <= 1'b0;
            busy_q    <= 1'b0;
            sync_q    <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_d_q    <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            avail_q   <= avail_d;
            ferr_q    <= ferr_d;
            oerr_q    <= oerr_d;
            busy_q    <= busy_d;
            sync_q    <= UartRx;
            rx_s_q    <= sync_q;
            rx_d_q    <= rx_s_q;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end

    assign rx_data     = data_q;
    assign rx_avail    = avail_q;
    assign frame_err   = ferr_q;
    assign overrun_err = oerr_q;
    assign busy        = busy_q;
`ifdef UART_RX_PARITY_EN
    assign parity_err  = perr_q;
`endif
endmodule
